// File: rtl/vec_acc_pkg.sv
// Shared types and constants for the vector accelerator command sequencer.
// The optional checksum byte is enabled with the VSEQ_CHECKSUM_EN macro.
package vec_acc_pkg;

  localparam int NBYTES_DEF = 1024;
  localparam int ACC_W = 26;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    OP_SUM  = 2'd0,
    OP_AVG  = 2'd1,
    OP_MAN  = 2'd2,
    OP_EUC2 = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX,
    ST_FINISH,
    ST_ERR
  } seq_state_e;

  // Which kind of byte group is currently streaming out; decides what follows its last byte.
  typedef enum logic [1:0] {
    GRP_ELEM,
    GRP_FINAL,
    GRP_CSUM,
    GRP_ERR
  } grp_e;

  function automatic logic is_reduction(input op_e op);
    return (op == OP_MAN) || (op == OP_EUC2);
  endfunction

endpackage

// File: rtl/vec_elem_alu.sv
// Combinational per-element datapath: elementwise SUM/AVG result and the
// MAN/EUC2 reduction term for one (a, b) pair.
module vec_elem_alu
  import vec_acc_pkg::*;
(
  input  op_e         op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [8:0]  elem,
  output logic [15:0] term
);

  logic [8:0] sum;
  logic [7:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = (a >= b) ? (a - b) : (b - a);
    elem = '0;
    term = '0;
    case (op)
      OP_SUM:  elem = sum;
      OP_AVG:  elem = {1'b0, sum[8:1]};
      OP_MAN:  term = {8'd0, diff};
      OP_EUC2: term = {8'd0, diff} * {8'd0, diff};
      default: begin
        elem = '0;
        term = '0;
      end
    endcase
  end

endmodule

// File: rtl/vec_op_sequencer.sv
// Command sequencer: reads A/B element pairs, computes SUM/AVG/MAN/EUC2 and
// streams result bytes to the UART TX. VSEQ_CHECKSUM_EN appends an XOR checksum byte.
module vec_op_sequencer
  import vec_acc_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_code,
  input  logic [1:0]        vec_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_byte_a,
  input  logic [7:0]        rd_byte_b,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0]        WAIT_LAST = 4'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NBYTES - 1);

  seq_state_e        state;
  op_e               op;
  grp_e              grp;
  logic [ADDR_W-1:0] idx;
  logic [ACC_W-1:0]  acc;
  logic [31:0]       out_sr;
  logic [2:0]        bytes_left;
  logic [3:0]        wcnt;
`ifdef VSEQ_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic [8:0]       elem_res;
  logic [15:0]      red_term;
  logic [ACC_W-1:0] acc_next;
  logic             last_idx;
  logic             cmd_bad;
  logic             stream_end;

  vec_elem_alu u_alu (
    .op   (op),
    .a    (rd_byte_a),
    .b    (rd_byte_b),
    .elem (elem_res),
    .term (red_term)
  );

  assign acc_next = acc + ACC_W'(red_term);
  assign last_idx = (idx == IDX_LAST);
  assign cmd_bad  = (cmd_code > 8'd3) || (vec_ready != 2'b11);

  // The last byte of the result stream has just been acknowledged.
  assign stream_end = (state == ST_WAIT_TX) && tx_done && (bytes_left == 3'd1) &&
                      ((grp == GRP_FINAL) || ((grp == GRP_ELEM) && last_idx));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= ST_IDLE;
      op         <= OP_SUM;
      grp        <= GRP_ELEM;
      idx        <= '0;
      acc        <= '0;
      out_sr     <= '0;
      bytes_left <= '0;
      wcnt       <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef VSEQ_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op   <= op_e'(cmd_code[1:0]);
            busy <= 1'b1;
            idx  <= '0;
            acc  <= '0;
`ifdef VSEQ_CHECKSUM_EN
            csum <= '0;
`endif
            if (cmd_bad) begin
              out_sr     <= {24'd0, ERR_BYTE};
              bytes_left <= 3'd1;
              grp        <= GRP_ERR;
              state      <= ST_SEND;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          rd_en   <= 1'b1;
          rd_addr <= idx;
          wcnt    <= '0;
          state   <= ST_WAIT_RD;
        end

        // rd_en is visible in the first WAIT_RD cycle, so EXEC lands exactly RD_LAT cycles later.
        ST_WAIT_RD: begin
          rd_en <= 1'b0;
          if (wcnt == WAIT_LAST) begin
            state <= ST_EXEC;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end

        ST_EXEC: begin
          if (is_reduction(op)) begin
            acc <= acc_next;
            if (last_idx) begin
              idx        <= '0;
              out_sr     <= 32'(acc_next);
              bytes_left <= (op == OP_MAN) ? 3'd3 : 3'd4;
              grp        <= GRP_FINAL;
              state      <= ST_SEND;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= ST_ISSUE;
            end
          end else begin
            out_sr     <= {23'd0, elem_res};
            bytes_left <= (op == OP_SUM) ? 3'd2 : 3'd1;
            grp        <= GRP_ELEM;
            state      <= ST_SEND;
          end
        end

        ST_SEND: begin
          tx_dv   <= 1'b1;
          tx_byte <= out_sr[7:0];
`ifdef VSEQ_CHECKSUM_EN
          if ((grp == GRP_ELEM) || (grp == GRP_FINAL)) begin
            csum <= csum ^ out_sr[7:0];
          end
`endif
          state <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          tx_dv <= 1'b0;
          if (tx_done) begin
            if (bytes_left > 3'd1) begin
              out_sr     <= out_sr >> 8;
              bytes_left <= bytes_left - 3'd1;
              state      <= ST_SEND;
            end else if (stream_end) begin
              idx <= '0;
`ifdef VSEQ_CHECKSUM_EN
              out_sr     <= {24'd0, csum};
              bytes_left <= 3'd1;
              grp        <= GRP_CSUM;
              state      <= ST_SEND;
`else
              acc   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FINISH;
`endif
            end else begin
              case (grp)
                GRP_ELEM: begin
                  idx   <= idx + ADDR_W'(1);
                  state <= ST_ISSUE;
                end
                GRP_ERR: begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_ERR;
                end
                default: begin
                  idx   <= '0;
                  acc   <= '0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_FINISH;
                end
              endcase
            end
          end
        end

        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_ERR: begin
          err   <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Scoreboard bench for vec_op_sequencer with a RD_LAT=2 BRAM model and a UART TX
// model answering tx_done 20 cycles after tx_dv. Vectors shortened to keep runtime small.
module tb_vec_op_sequencer;

  localparam int NB = 256;
  localparam int AW = 8;

  logic          clk_in;
  logic          reset;
  logic          cmd_valid;
  logic [7:0]    cmd_code;
  logic [1:0]    vec_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_byte_a;
  logic [7:0]    rd_byte_b;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_done;
  logic          busy;
  logic          done;
  logic          err;

  logic [7:0] mem_a [NB];
  logic [7:0] mem_b [NB];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b;

  logic [7:0] exp_q[$];
  int n_cmp;
  int n_bad;
  int done_cnt;
  int err_cnt;

  vec_op_sequencer #(
    .NBYTES (NB),
    .ADDR_W (AW),
    .RD_LAT (2)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .vec_ready (vec_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_byte_a (rd_byte_a),
    .rd_byte_b (rd_byte_b),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .tx_done   (tx_done),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- BRAM model, two-cycle read latency ----------------
  always @(posedge clk_in) begin
    if (rd_en) begin
      pipe_a <= mem_a[rd_addr];
      pipe_b <= mem_b[rd_addr];
    end
    rd_byte_a <= pipe_a;
    rd_byte_b <= pipe_b;
  end

  // ---------------- UART TX model ----------------
  initial begin : uart_model
    logic [7:0] held;
    tx_done = 1'b0;
    forever begin
      @(negedge clk_in);
      if (tx_dv && !reset) begin
        held = tx_byte;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk_in);
          if (reset) break;
          check_eq("tx_byte_held", tx_byte, held);
        end
        if (!reset) begin
          tx_done = 1'b1;
          @(negedge clk_in);
          tx_done = 1'b0;
        end
      end
    end
  end

  // ---------------- output monitor / scoreboard pop ----------------
  initial begin : monitor
    logic [7:0] e;
    done_cnt = 0;
    err_cnt  = 0;
    forever begin
      @(negedge clk_in);
      if (!reset) begin
        if (tx_dv) begin
          if (exp_q.size() == 0) begin
            check_eq("tx_unexpected_byte", 32'(tx_byte) | 32'h100, 32'(tx_byte));
          end else begin
            e = exp_q.pop_front();
            check_eq("tx_byte", tx_byte, e);
            check_eq("busy_during_tx", busy, 1'b1);
          end
        end
        if (done) begin
          done_cnt++;
          check_eq("busy_at_done", busy, 1'b0);
        end
        if (err) begin
          err_cnt++;
          check_eq("busy_at_err", busy, 1'b0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_vectors(input int pattern);
    for (int i = 0; i < NB; i++) begin
      case (pattern)
        0: begin mem_a[i] = 8'd3;           mem_b[i] = 8'd1;                 end
        1: begin mem_a[i] = 8'(i % 256);    mem_b[i] = 8'(255 - (i % 256));  end
        2: begin mem_a[i] = 8'd5;           mem_b[i] = 8'd2;                 end
        default: begin mem_a[i] = 8'd0;     mem_b[i] = 8'd255;               end
      endcase
    end
  endtask

  // Reference model: expected byte stream of a valid op over the current vectors.
  task automatic push_expected(input logic [7:0] code);
    logic [8:0]  s;
    int unsigned red;
    int          d;
    logic [7:0]  x;
    logic [7:0]  b;
    red = 0;
    x   = 8'd0;
    for (int i = 0; i < NB; i++) begin
      s = {1'b0, mem_a[i]} + {1'b0, mem_b[i]};
      d = int'(mem_a[i]) - int'(mem_b[i]);
      case (code)
        8'h00: begin
          b = s[7:0];          exp_q.push_back(b); x ^= b;
          b = {7'd0, s[8]};    exp_q.push_back(b); x ^= b;
        end
        8'h01: begin
          b = 8'(s / 2);       exp_q.push_back(b); x ^= b;
        end
        8'h02: red += (d < 0) ? -d : d;
        default: red += d * d;
      endcase
    end
    if (code == 8'h02 || code == 8'h03) begin
      for (int k = 0; k < ((code == 8'h02) ? 3 : 4); k++) begin
        b = 8'(red >> (8 * k));
        exp_q.push_back(b);
        x ^= b;
      end
    end
`ifdef VSEQ_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_cmd(input logic [7:0] code);
    @(negedge clk_in);
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  // mid_mode bit0: stray cmd_valid mid-run; bit1: drop vec_ready mid-run.
  task automatic run_op(input logic [7:0] code, input logic [1:0] vr,
                        input int mid_mode, input bit chk_addr0, input string name);
    bit reject;
    bit ended;
    bit seen_rd;
    int d0;
    int e0;
    reject = (code > 8'h03) || (vr != 2'b11);
    if (reject) exp_q.push_back(8'hEE);
    else        push_expected(code);
    d0 = done_cnt;
    e0 = err_cnt;
    vec_ready = vr;
    pulse_cmd(code);
    check_eq({name, "_busy_after_accept"}, busy, 1'b1);
    if (chk_addr0) begin
      seen_rd = 1'b0;
      for (int c = 0; c < 50 && !seen_rd; c++) begin
        if (rd_en) begin
          seen_rd = 1'b1;
          check_eq({name, "_first_rd_addr"}, 32'(rd_addr), 32'd0);
        end else begin
          @(negedge clk_in);
        end
      end
      check_eq({name, "_first_rd_seen"}, seen_rd, 1'b1);
    end
    ended = 1'b0;
    for (int cyc = 0; cyc < 40000 && !ended; cyc++) begin
      @(negedge clk_in);
      if (cyc == 200) begin
        if (mid_mode[0]) begin cmd_valid = 1'b1; cmd_code = 8'h00; end
        if (mid_mode[1]) vec_ready = 2'b00;
      end
      if (cyc == 201) cmd_valid = 1'b0;
      if (done_cnt != d0 || err_cnt != e0) ended = 1'b1;
    end
    repeat (5) @(negedge clk_in);
    check_eq({name, "_end_seen"}, ended, 1'b1);
    check_eq({name, "_done_pulses"}, 32'(done_cnt - d0), reject ? 32'd0 : 32'd1);
    check_eq({name, "_err_pulses"}, 32'(err_cnt - e0), reject ? 32'd1 : 32'd0);
    check_eq({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check_eq({name, "_busy_idle"}, busy, 1'b0);
    exp_q.delete();
    vec_ready = 2'b11;
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_tx_dv"},   tx_dv,   1'b0);
    check_eq({pfx, "_tx_byte"}, tx_byte, 8'd0);
    check_eq({pfx, "_rd_en"},   rd_en,   1'b0);
    check_eq({pfx, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check_eq({pfx, "_busy"},    busy,    1'b0);
    check_eq({pfx, "_done"},    done,    1'b0);
    check_eq({pfx, "_err"},     err,     1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit hit;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = 8'h00;
    vec_ready = 2'b11;
    pipe_a    = 8'd0;
    pipe_b    = 8'd0;
    load_vectors(0);
    repeat (3) @(posedge clk_in);
    #1;
    check_outputs_zero("reset");
    @(negedge clk_in);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);

    load_vectors(0);
    run_op(8'h00, 2'b11, 0, 1'b1, "sum");
    load_vectors(1);
    run_op(8'h01, 2'b11, 1, 1'b0, "avg_midcmd");
    load_vectors(2);
    run_op(8'h02, 2'b11, 2, 1'b0, "man_vrdrop");
    load_vectors(3);
    run_op(8'h03, 2'b11, 0, 1'b0, "euc2");
    run_op(8'h00, 2'b10, 0, 1'b0, "rej_notready");
    run_op(8'h07, 2'b11, 0, 1'b0, "rej_opcode");

    // Abort a SUM partway through with a reset.
    load_vectors(0);
    push_expected(8'h00);
    pulse_cmd(8'h00);
    hit = 1'b0;
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk_in);
      if (rd_en && rd_addr == AW'(200)) hit = 1'b1;
    end
    check_eq("abort_point_reached", hit, 1'b1);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    check_outputs_zero("abort");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_in);
      #1;
      check_eq("abort_tx_dv_low", tx_dv, 1'b0);
    end
    exp_q.delete();
    @(negedge clk_in);
    reset = 1'b0;
    repeat (5) @(negedge clk_in);

    load_vectors(1);
    run_op(8'h01, 2'b11, 0, 1'b1, "avg_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
